// File: rtl/svm_coef_loader_pkg.sv
// Shared constants and state encoding for the SVM coefficient loader.
//   COEF_W : coefficient / bias width (integer + fraction bits)
//   N_COEF : coefficients packed into one RAM line
//   N_LINE : RAM lines per SVM model
//   ADDR_W : RAM line address width
package svm_coef_loader_pkg;

  localparam int unsigned COEF_W = 12;
  localparam int unsigned N_COEF = 105;
  localparam int unsigned N_LINE = 36;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
    ST_BIAS  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // States in which a model load is in progress.
  function automatic logic is_busy(input state_e s);
    return (s == ST_FILL) || (s == ST_WRITE) || (s == ST_BIAS);
  endfunction

endpackage

// File: rtl/svm_coef_loader_coef_packer.sv
// Packs a stream of coefficients into one RAM line.
//   clear  : restart the line at coefficient 0
//   beat   : accept s_data into the current coefficient slot
//   s_data : incoming coefficient
//   last_c : the current slot is the final one of the line
//   line   : last completed line; updates only when a line completes
module svm_coef_loader_coef_packer #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned N_COEF = 105
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     beat,
  input  logic [COEF_W-1:0]        s_data,
  output logic                     last_c,
  output logic [COEF_W*N_COEF-1:0] line
);

  localparam int unsigned CNT_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  logic [CNT_W-1:0]                  coef_cnt;
  // Slots 0..N_COEF-2; the final slot goes straight into the output line.
  logic [N_COEF-2:0][COEF_W-1:0]     low_q;

  assign last_c = (coef_cnt == CNT_W'(N_COEF - 1));

  // Slot index counter, partial line and completed-line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_cnt <= '0;
      low_q    <= '0;
      line     <= '0;
    end else if (clear) begin
      coef_cnt <= '0;
    end else if (beat) begin
      if (last_c) begin
        coef_cnt <= '0;
        line     <= {s_data, low_q};
      end else begin
        low_q[coef_cnt] <= s_data;
        coef_cnt        <= coef_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/svm_coef_loader.sv
// Loads one SVM model (N_LINE packed coefficient lines plus a bias) from a
// valid/ready stream into the SVM's line RAM and bias register.
//   clk, rst          : clock, asynchronous active-low reset
//   start, abort      : begin a load / cancel a load (abort wins)
//   s_valid, s_ready, s_data : coefficient stream, bias beat last
//   addr_a, write_en, o_data_a : RAM line write port
//   bias, b_load      : bias value and one-cycle load strobe
//   busy, done        : load in progress / model loaded (level)
module svm_coef_loader #(
  parameter int unsigned COEF_W = svm_coef_loader_pkg::COEF_W,
  parameter int unsigned N_COEF = svm_coef_loader_pkg::N_COEF,
  parameter int unsigned N_LINE = svm_coef_loader_pkg::N_LINE,
  parameter int unsigned ADDR_W = svm_coef_loader_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [COEF_W-1:0]        s_data,
  output logic [ADDR_W-1:0]        addr_a,
  output logic                     write_en,
  output logic [COEF_W*N_COEF-1:0] o_data_a,
  output logic [COEF_W-1:0]        bias,
  output logic                     b_load,
  output logic                     busy,
  output logic                     done
);

  import svm_coef_loader_pkg::*;

  localparam int unsigned LINE_W = (N_LINE > 1) ? $clog2(N_LINE) : 1;

  state_e              state, state_n;
  logic [LINE_W-1:0]   line_cnt, line_cnt_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [COEF_W-1:0]   bias_n;
  logic                b_load_n;
  logic                hs_c;
  logic                pk_clear_c;
  logic                pk_beat_c;
  logic                last_c;

  assign hs_c = s_valid & s_ready;

  svm_coef_loader_coef_packer #(
    .COEF_W (COEF_W),
    .N_COEF (N_COEF)
  ) u_packer (
    .clk    (clk),
    .rst_n  (rst),
    .clear  (pk_clear_c),
    .beat   (pk_beat_c),
    .s_data (s_data),
    .last_c (last_c),
    .line   (o_data_a)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    line_cnt_n = line_cnt;
    addr_n     = addr_a;
    bias_n     = bias;
    b_load_n   = 1'b0;
    pk_clear_c = 1'b0;
    pk_beat_c  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n    = ST_FILL;
          line_cnt_n = '0;
          pk_clear_c = 1'b1;
        end
      end
      ST_FILL: begin
        pk_beat_c = hs_c;
        if (hs_c && last_c) begin
          state_n = ST_WRITE;
          addr_n  = ADDR_W'(line_cnt);
        end
      end
      ST_WRITE: begin
        if (line_cnt == LINE_W'(N_LINE - 1)) begin
          state_n = ST_BIAS;
        end else begin
          line_cnt_n = line_cnt + LINE_W'(1);
          state_n    = ST_FILL;
        end
      end
      ST_BIAS: begin
        if (hs_c) begin
          bias_n   = s_data;
          b_load_n = 1'b1;
          state_n  = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Abort overrides everything, including a pending line write or bias load.
    if (abort) begin
      state_n    = ST_IDLE;
      line_cnt_n = '0;
      addr_n     = addr_a;
      bias_n     = bias;
      b_load_n   = 1'b0;
      pk_beat_c  = 1'b0;
      pk_clear_c = 1'b1;
    end
  end

  // State and registered outputs; flags are decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      line_cnt <= '0;
      addr_a   <= '0;
      bias     <= '0;
      b_load   <= 1'b0;
      write_en <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      line_cnt <= line_cnt_n;
      addr_a   <= addr_n;
      bias     <= bias_n;
      b_load   <= b_load_n;
      write_en <= (state_n == ST_WRITE);
      s_ready  <= (state_n == ST_FILL) || (state_n == ST_BIAS);
      busy     <= is_busy(state_n);
      done     <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_svm_coef_loader.sv
// Self-checking bench for svm_coef_loader: control-vector table plus
// full-model loads checked against a scoreboard of expected RAM lines.
module tb_svm_coef_loader;

  localparam int COEF_W = 12;
  localparam int N_COEF = 105;
  localparam int N_LINE = 36;
  localparam int ADDR_W = 6;
  localparam int LW     = COEF_W * N_COEF;
  localparam int NBEATS = N_COEF * N_LINE + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              s_valid;
  logic              s_ready;
  logic [COEF_W-1:0] s_data;
  logic [ADDR_W-1:0] addr_a;
  logic              write_en;
  logic [LW-1:0]     o_data_a;
  logic [COEF_W-1:0] bias;
  logic              b_load;
  logic              busy;
  logic              done;

  svm_coef_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .addr_a   (addr_a),
    .write_en (write_en),
    .o_data_a (o_data_a),
    .bias     (bias),
    .b_load   (b_load),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LW-1:0]     data;
    int                cyc;
  } wr_t;

  typedef struct {
    logic start;
    logic abort;
    logic valid;
    logic ready;
    logic busy;
    logic done;
  } vec_t;

  wr_t                         exp_q[$];
  logic [COEF_W-1:0]           bias_q[$];
  logic [N_COEF-1:0][COEF_W-1:0] exp_line;
  logic [COEF_W-1:0]           bias_beat;
  int                          bidx;
  int                          cyc = 0;
  int                          n_wr = 0;
  int                          n_bl = 0;
  int                          n_checks = 0;
  int                          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every write and bias load must match the model.
  always @(negedge clk) begin : mon
    wr_t                           e;
    logic [N_COEF-1:0][COEF_W-1:0] act_l;
    logic [N_COEF-1:0][COEF_W-1:0] exp_l;
    logic [6:0]                    idx;
    logic [COEF_W-1:0]             eb;
    if (write_en === 1'b1) begin
      n_wr++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d at cycle %0d, no write required", addr_a, cyc);
      end else begin
        e = exp_q.pop_front();
        if (addr_a !== e.addr || o_data_a !== e.data || cyc != e.cyc) begin
          act_l = o_data_a;
          exp_l = e.data;
          idx   = '0;
          for (int i = N_COEF - 1; i >= 0; i--)
            if (act_l[7'(i)] !== exp_l[7'(i)]) idx = 7'(i);
          n_fail++;
          $display("FAIL write_line: addr %0d cycle %0d slice[%0d]=%h, required addr %0d cycle %0d slice[%0d]=%h",
                   addr_a, cyc, idx, act_l[idx], e.addr, e.cyc, idx, exp_l[idx]);
        end
      end
    end
    if (b_load === 1'b1) begin
      n_bl++;
      n_checks++;
      if (bias_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_b_load: bias %h at cycle %0d", bias, cyc);
      end else begin
        eb = bias_q.pop_front();
        if (bias !== eb) begin
          n_fail++;
          $display("FAIL bias_value: got %h, required %h", bias, eb);
        end
      end
    end
  end

  function automatic logic [COEF_W-1:0] beat_val(input int b);
    if (b == N_COEF * N_LINE) return bias_beat;
    return COEF_W'(b);
  endfunction

  // Scoreboard producer: called for each beat the bench sees accepted.
  task automatic record(input int b, input logic [COEF_W-1:0] v);
    wr_t        e;
    logic [6:0] k;
    k = 7'(b % N_COEF);
    if (b >= N_COEF * N_LINE) begin
      bias_q.push_back(v);
    end else begin
      exp_line[k] = v;
      if (int'(k) == N_COEF - 1) begin
        e.addr = ADDR_W'(b / N_COEF);
        e.data = exp_line;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive beats until bidx reaches target; optional start pulse at beat start_at.
  task automatic feed(input int target, input int pct, input int start_at);
    int guard;
    bit pulsed;
    guard  = 0;
    pulsed = 1'b0;
    while (bidx < target && guard < 20000) begin
      s_valid = ($urandom_range(99) < 32'(pct));
      s_data  = beat_val(bidx);
      start   = (bidx == start_at) && !pulsed;
      if (start) pulsed = 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        record(bidx, s_data);
        bidx++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    n_checks++;
    if (bidx < target) begin
      n_fail++;
      $display("FAIL feed_timeout: reached beat %0d, required %0d", bidx, target);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"},  32'(s_ready),  32'(0));
    chk({tag, "_write_en"}, 32'(write_en), 32'(0));
    chk({tag, "_b_load"},   32'(b_load),   32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
    chk({tag, "_done"},     32'(done),     32'(0));
    chk({tag, "_addr_a"},   32'(addr_a),   32'(0));
    chk({tag, "_bias"},     32'(bias),     32'(0));
    chk({tag, "_data_zero"}, 32'(o_data_a === '0), 32'(1));
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vec[9];
    int   w0;
    int   b0;

    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    bidx      = 0;
    bias_beat = 12'hEC4;
    exp_line  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Control-protocol vectors, one clock each.
    for (int i = 0; i < 9; i++) begin
      start   = vec[i].start;
      abort   = vec[i].abort;
      s_valid = vec[i].valid;
      s_data  = COEF_W'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vec[i].ready));
      chk($sformatf("vec%0d_busy", i),    32'(busy),    32'(vec[i].busy));
      chk($sformatf("vec%0d_done", i),    32'(done),    32'(vec[i].done));
    end
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;

    // Full load, s_valid always high.
    bidx = 0; bias_beat = 12'hEC4; w0 = n_wr; b0 = n_bl;
    do_start();
    feed(NBEATS, 100, -1);
    chk("A_b_load_hi", 32'(b_load), 32'(1));
    chk("A_bias", 32'(bias), 32'(12'hEC4));
    @(posedge clk);
    #1;
    chk("A_done", 32'(done), 32'(1));
    chk("A_s_ready", 32'(s_ready), 32'(0));
    chk("A_busy", 32'(busy), 32'(0));
    chk("A_b_load_lo", 32'(b_load), 32'(0));
    chk("A_writes", 32'(n_wr - w0), 32'(N_LINE));
    chk("A_b_loads", 32'(n_bl - b0), 32'(1));
    chk("A_q_empty", 32'(exp_q.size()), 32'(0));
    chk("A_addr_hold", 32'(addr_a), 32'(N_LINE - 1));
    chk("A_data_hold", 32'(o_data_a === exp_line), 32'(1));

    // Reload from DONE with 50% s_valid gaps and a negative bias.
    bidx = 0; bias_beat = 12'hF80; w0 = n_wr; b0 = n_bl;
    do_start();
    chk("B_done_drop", 32'(done), 32'(0));
    chk("B_busy", 32'(busy), 32'(1));
    feed(NBEATS, 50, -1);
    chk("B_b_load_hi", 32'(b_load), 32'(1));
    chk("B_bias", 32'(bias), 32'(12'hF80));
    chk("B_done", 32'(done), 32'(1));
    chk("B_s_ready", 32'(s_ready), 32'(0));
    s_valid = 1'b1;
    s_data  = 12'h055;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("B_post%0d_b_load", i), 32'(b_load), 32'(0));
      chk($sformatf("B_post%0d_done", i), 32'(done), 32'(1));
      chk($sformatf("B_post%0d_s_ready", i), 32'(s_ready), 32'(0));
      chk($sformatf("B_post%0d_bias", i), 32'(bias), 32'(12'hF80));
    end
    s_valid = 1'b0;
    chk("B_writes", 32'(n_wr - w0), 32'(N_LINE));
    chk("B_b_loads", 32'(n_bl - b0), 32'(1));

    // Start pulse during line 10 must be ignored.
    bidx = 0; bias_beat = 12'h123; w0 = n_wr;
    do_start();
    feed(NBEATS, 100, 10 * N_COEF + 50);
    @(posedge clk);
    #1;
    chk("C_writes", 32'(n_wr - w0), 32'(N_LINE));
    chk("C_done", 32'(done), 32'(1));

    // Abort together with start after 500 beats, then a clean reload.
    bidx = 0; bias_beat = 12'h7FF;
    do_start();
    feed(500, 100, -1);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("D_busy", 32'(busy), 32'(0));
    chk("D_done", 32'(done), 32'(0));
    chk("D_s_ready", 32'(s_ready), 32'(0));
    w0 = n_wr;
    s_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("D_no_writes", 32'(n_wr - w0), 32'(0));
    chk("D_idle_s_ready", 32'(s_ready), 32'(0));
    bidx = 0; w0 = n_wr;
    do_start();
    feed(NBEATS, 100, -1);
    @(posedge clk);
    #1;
    chk("D_reload_writes", 32'(n_wr - w0), 32'(N_LINE));
    chk("D_reload_done", 32'(done), 32'(1));

    // Asynchronous reset during the write of line 5.
    bidx = 0;
    do_start();
    feed(6 * N_COEF, 100, -1);
    chk("E_write_en", 32'(write_en), 32'(1));
    chk("E_addr", 32'(addr_a), 32'(5));
    #2;
    rst = 1'b0;
    #1;
    check_zero("E_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    w0 = n_wr;
    s_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("E_no_writes", 32'(n_wr - w0), 32'(0));
    chk("E_s_ready", 32'(s_ready), 32'(0));
    chk("E_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_coef_loader.md
SVM_COEF_LOADER -- requirements
Module: svm_coef_loader

Interface
REQ-001 Parameter COEF_W, default 12, sets the coefficient and bias width (FEA_I+FEA_F).
REQ-002 Parameter N_COEF, default 105, sets the coefficients per RAM line (ROW*COL).
REQ-003 Parameter N_LINE, default 36, sets the RAM lines per SVM model.
REQ-004 Parameter ADDR_W, default 6, sets the RAM address width.
REQ-005 Ports SHALL be, clock and reset first:
  clk        in   1                 single clock, rising edge
  rst        in   1                 asynchronous, active-low reset
  start      in   1                 one-cycle pulse that begins a model load
  abort      in   1                 cancels a load in progress
  s_valid    in   1                 stream beat valid
  s_ready    out  1                 stream beat accepted when s_valid&s_ready
  s_data     in   COEF_W            coefficient or bias beat, two's complement
  addr_a     out  ADDR_W            RAM line address to svm
  write_en   out  1                 RAM write strobe to svm
  o_data_a   out  COEF_W*N_COEF     packed RAM line to svm i_data
  bias       out  COEF_W            bias value to svm
  b_load     out  1                 bias load strobe to svm
  busy       out  1                 load in progress
  done       out  1                 model fully loaded; level signal

Function
REQ-006 FSM states SHALL be IDLE, FILL, WRITE, BIAS and DONE.
REQ-007 IDLE/DONE + start: go to FILL; clear line_cnt and coef_cnt; drop done.
REQ-008 FILL: s_ready=1; each handshake places s_data at bits [k*COEF_W +: COEF_W], k=coef_cnt, then coef_cnt++.
REQ-009 Handshake with coef_cnt==N_COEF-1: go to WRITE; clear coef_cnt.
REQ-010 WRITE lasts exactly one cycle: s_ready=0, write_en=1, addr_a=line_cnt, o_data_a=packed line.
REQ-011 Leaving WRITE: if line_cnt==N_LINE-1 go to BIAS, else line_cnt++ and return to FILL.
REQ-012 write_en SHALL assert in the cycle after the 105th handshake; line period SHALL be N_COEF+1 cycles at full s_valid.
REQ-013 BIAS: s_ready=1; the first handshake registers bias=s_data, and b_load=1 for exactly the next cycle while the FSM enters DONE.
REQ-014 DONE: done=1, s_ready=0; done SHALL hold until start or abort.
REQ-015 busy SHALL equal (state is FILL, WRITE or BIAS).
REQ-016 start while busy SHALL be ignored.
REQ-017 abort in any state SHALL go to IDLE next cycle, clear counters and done, and suppress any write_en/b_load that cycle; abort wins over a simultaneous start.
REQ-018 s_valid while s_ready=0 SHALL neither be consumed nor change state; no beat is dropped or duplicated across WRITE.
REQ-019 addr_a and o_data_a SHALL hold their last written values when write_en=0; bias SHALL hold until the next b_load.
REQ-020 Total accepted beats per load SHALL be N_COEF*N_LINE+1 (3781 at defaults), with the bias beat last.

Reset
REQ-021 rst low SHALL asynchronously force: state IDLE, counters 0, s_ready 0, write_en 0, b_load 0, busy 0, done 0, addr_a 0, o_data_a 0, bias 0.
REQ-022 Reset mid-load SHALL discard partial lines; no write_en is issued for them.

Structure
REQ-023 A shared hog_svm package SHALL hold COEF_W, N_COEF, N_LINE, ADDR_W and the state encoding.
REQ-024 The line packer (shift/index register plus coef_cnt) MAY be one sub-module, coef_packer; the FSM stays in svm_coef_loader.

Verification
REQ-025 Reset, start, 3781 beats with line L coef k = L*105+k (mod 4096), s_valid always 1 -> 36 write_en pulses with addr 0..35 and slice k matching; b_load once; done=1.
REQ-026 Random s_valid gaps (50%) -> RAM image identical to REQ-025; no beat lost at WRITE cycles.
REQ-027 Bias beat 12'hF80 -> bias=12'hF80, b_load high exactly 1 cycle, then done=1 with s_ready=0.
REQ-028 start pulse during line 10 -> ignored; load completes normally with 36 writes.
REQ-029 abort after 500 beats, same cycle as start -> IDLE, done=0, no further write_en; a new start reloads from addr 0.
REQ-030 rst low during WRITE of line 5 -> all outputs 0 asynchronously; no write_en after rst release until a new start.
